// File: rtl/seq_sorter.sv
// Sequential vector sorter: loads N unsigned W-bit elements, runs N odd-even
// transposition passes (one per clock), then presents the sorted vector.
module seq_sorter #(
  parameter int W    = 2,
  parameter int N    = 4,
  parameter int DESC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N*W-1:0]  r_data;
  logic [N*W-1:0]  r_out;
  logic [N*W-1:0]  w_passed;
  logic [CW-1:0]   r_pass;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_accept;
  logic            w_transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE can hand off its result and take a new vector on the same edge.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    w_accept   = 1'b0;
    w_transfer = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (r_pass == CW'(N)) begin
          w_transfer = 1'b1;
          w_next     = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = SORT;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Element 0 sits at the MSB end; pairs start at even or odd indices by pass parity.
  always_comb begin
    w_passed = r_data;
    w_a      = '0;
    w_b      = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == r_pass[0]) begin
        w_a = r_data[(N-i)*W-1 -: W];
        w_b = r_data[(N-i-1)*W-1 -: W];
        if ((DESC != 0) ? (w_a < w_b) : (w_a > w_b)) begin
          w_passed[(N-i)*W-1 -: W]   = w_b;
          w_passed[(N-i-1)*W-1 -: W] = w_a;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_out  <= '0;
      r_pass <= '0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_pass <= '0;
      end else if (r_state == SORT && !w_transfer) begin
        r_data <= w_passed;
        r_pass <= r_pass + CW'(1);
      end
      if (w_transfer) begin
        r_out <= r_data;
      end
    end
  end

  assign out_data = r_out;

endmodule

// File: tb/tb_seq_sorter.sv
// Self-checking bench for seq_sorter: directed vector table on descending and
// ascending instances, hold/back-to-back and reset corner cases, wide instance.
module tb_seq_sorter;

  typedef struct {
    logic [7:0] din;
    logic [7:0] expDesc;
    logic [7:0] expAsc;
    string      name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid  [2];
  logic        inReady  [2];
  logic        outValid [2];
  logic        outReady [2];
  logic        busy     [2];
  logic [7:0]  inData   [2];
  logic [7:0]  outData  [2];

  logic        wInValid;
  logic        wInReady;
  logic        wOutValid;
  logic        wOutReady;
  logic        wBusy;
  logic [31:0] wInData;
  logic [31:0] wOutData;

  int checks = 0;
  int errors = 0;
  vec_t table_q [8];

  seq_sorter #(.W(2), .N(4), .DESC(1)) dutDesc (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_data(inData[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(outData[0]), .busy(busy[0])
  );

  seq_sorter #(.W(2), .N(4), .DESC(0)) dutAsc (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_data(inData[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(outData[1]), .busy(busy[1])
  );

  seq_sorter #(.W(4), .N(8), .DESC(1)) dutWide (
    .clk(clk), .rst_n(rst_n), .in_valid(wInValid), .in_ready(wInReady),
    .in_data(wInData), .out_valid(wOutValid), .out_ready(wOutReady),
    .out_data(wOutData), .busy(wBusy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Counting-sort reference for a 4x2-bit vector, element 0 at the MSB end.
  function automatic logic [7:0] modelSort(input logic [7:0] v, input bit desc);
    int cnt [4];
    int k;
    int val;
    logic [7:0] r;
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) cnt[v[i*2 +: 2]]++;
    k = 0;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      val = desc ? 3 - s : s;
      for (int c = 0; c < cnt[val]; c++) begin
        r[(3-k)*2 +: 2] = val[1:0];
        k++;
      end
    end
    return r;
  endfunction

  task automatic applyStimulus(input int sel, input logic [7:0] din,
                               input logic [7:0] expected, input string name);
    int edges;
    int waits;
    @(negedge clk);
    inValid[sel]  = 1'b1;
    inData[sel]   = din;
    outReady[sel] = 1'b1;
    waits = 0;
    while (!inReady[sel] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) checkOutput({name, " ready timeout"}, 32'(inReady[sel]), 32'd1);
    @(posedge clk);
    #1;
    inValid[sel] = 1'b0;
    checkOutput({name, " busy"}, 32'(busy[sel]), 32'd1);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!outValid[sel] && edges < 20);
    checkOutput({name, " latency"}, 32'(edges), 32'd5);
    checkOutput({name, " data"}, 32'(outData[sel]), 32'(expected));
  endtask

  initial begin
    int edges;
    bit sawValid;
    bit holdOk;

    table_q[0] = '{8'h1B, 8'hE4, 8'h1B, "inc"};
    table_q[1] = '{8'hE4, 8'hE4, 8'h1B, "dec"};
    table_q[2] = '{8'hFF, 8'hFF, 8'hFF, "all3"};
    table_q[3] = '{8'h00, 8'h00, 8'h00, "all0"};
    table_q[4] = '{8'h6C, 8'hE4, 8'h1B, "rot"};
    table_q[5] = '{8'h52, 8'h94, 8'h16, "dup1"};
    table_q[6] = '{8'hC3, 8'hF0, 8'h0F, "ends"};
    table_q[7] = '{8'hA8, 8'hA8, 8'h2A, "three2"};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      inValid[s] = 1'b0; inData[s] = '0; outReady[s] = 1'b0;
    end
    wInValid = 1'b0; wInData = '0; wOutReady = 1'b0;
    #1;
    checkOutput("reset out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset out_data", 32'(outData[0]), 32'd0);
    checkOutput("reset busy", 32'(busy[0]), 32'd0);
    checkOutput("reset in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("reset wide out_data", wOutData, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, table_q[i].din, table_q[i].expDesc, {"desc ", table_q[i].name});
      applyStimulus(1, table_q[i].din, table_q[i].expAsc, {"asc ", table_q[i].name});
    end

    // Result held under backpressure, then consumed with a back-to-back accept.
    @(negedge clk);
    inValid[0] = 1'b1; inData[0] = 8'h1B; outReady[0] = 1'b1;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0; outReady[0] = 1'b0;
    edges = 0;
    while (!outValid[0] && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("hold first latency", 32'(edges), 32'd5);
    holdOk = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (!(outValid[0] === 1'b1 && outData[0] === 8'hE4 && inReady[0] === 1'b0)) holdOk = 1'b0;
    end
    checkOutput("hold stable", 32'(holdOk), 32'd1);
    checkOutput("hold data", 32'(outData[0]), 32'hE4);
    @(negedge clk);
    outReady[0] = 1'b1; inValid[0] = 1'b1; inData[0] = 8'h6C;
    #1;
    checkOutput("b2b in_ready", 32'(inReady[0]), 32'd1);
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    checkOutput("b2b out_valid drops", 32'(outValid[0]), 32'd0);
    checkOutput("b2b busy", 32'(busy[0]), 32'd1);
    checkOutput("b2b out_data kept during sort", 32'(outData[0]), 32'hE4);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!outValid[0] && edges < 20);
    checkOutput("b2b latency", 32'(edges), 32'd5);
    checkOutput("b2b data", 32'(outData[0]), 32'hE4);

    // Reset in the middle of a sort discards it.
    @(negedge clk);
    inValid[0] = 1'b1; inData[0] = 8'h1B; outReady[0] = 1'b1;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("midreset out_data", 32'(outData[0]), 32'd0);
    checkOutput("midreset busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 32'(inReady[0]), 32'd1);
    sawValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (outValid[0] !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("no result after reset", 32'(sawValid), 32'd0);
    applyStimulus(0, 8'hC3, 8'hF0, "post-reset accept");

    for (int d = 0; d < 256; d++) begin
      applyStimulus(0, d[7:0], modelSort(d[7:0], 1'b1), $sformatf("exh desc %02h", d));
      applyStimulus(1, d[7:0], modelSort(d[7:0], 1'b0), $sformatf("exh asc %02h", d));
    end

    @(negedge clk);
    wInValid = 1'b1; wInData = 32'h0123_4567; wOutReady = 1'b1;
    @(posedge clk);
    #1;
    wInValid = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!wOutValid && edges < 40);
    checkOutput("wide latency", 32'(edges), 32'd9);
    checkOutput("wide data", wOutData, 32'h7654_3210);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
